fetch_arbiter: RTL and testbench
================================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning byte-address width of the shared instruction memory (4 KB).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, meaning the read data returned for a rejected access.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 if_req_i  in  1  fetch-port request (read only).
REQ-007 if_addr_i  in  32  fetch byte address (PC).
REQ-008 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid_o / if_rdata_o  out  1 / 32  fetch response valid / instruction word.
REQ-010 ld_req_i, ld_we_i  in  1, 1  loader-port request; 1 = write word, 0 = read word.
REQ-011 ld_addr_i / ld_wdata_i  in  32 / 32  loader byte address / write data.
REQ-012 ld_lock_i  in  1  loader requests exclusive ownership (program download).
REQ-013 ld_gnt_o, ld_rvalid_o / ld_rdata_o  out  1, 1 / 32  loader grant, response valid / data.
REQ-014 mem_en_o, mem_we_o  out  1, 1  memory enable, write enable.
REQ-015 mem_addr_o / mem_wdata_o  out  ADDR_BITS / 32  memory byte address (low ADDR_BITS of winner's address) / write data.
REQ-016 mem_rdata_i  in  32  synchronous memory read data, valid the cycle after mem_en_o with mem_we_o=0.
REQ-017 locked_o  out  1  arbiter in LOCKED state.
REQ-018 err_o  out  1  one-cycle pulse with any error response; err_cnt_o  out  8  saturating count of rejected accesses.

Function
REQ-019 SHALL be a two-state FSM: SHARED (round-robin between ports) and LOCKED (loader only).
REQ-020 In SHARED, a single requester SHALL be granted in the same cycle; with both requesting, the port not granted most recently SHALL win; last-winner register SHALL update only on a grant.
REQ-021 Grants SHALL be combinational from requests and registered state; at most one gnt per cycle; a request without gnt SHALL be held by the requester and stays pending.
REQ-022 SHARED->LOCKED when ld_lock_i=1 at a clock edge; the transition edge SHALL still honour that cycle's grant, and from the next cycle if_gnt_o SHALL be 0.
REQ-023 LOCKED->SHARED when ld_lock_i=0 at a clock edge; in LOCKED ld_gnt_o = ld_req_i.
REQ-024 Granted reads SHALL drive mem_en_o=1, mem_we_o=0; response rvalid on the winning port exactly one cycle after grant, rdata = mem_rdata_i; full back-to-back throughput (one grant per cycle).
REQ-025 Granted loader writes SHALL drive mem_en_o=1, mem_we_o=1, mem_wdata_o=ld_wdata_i; ld_rvalid_o SHALL pulse one cycle later with ld_rdata_o=0 (write acknowledge).
REQ-026 A granted access with addr[1:0]!=0 or addr[31:ADDR_BITS]!=0 SHALL be rejected: mem_en_o=0; response one cycle later with rdata=ERR_DATA, err_o=1.
REQ-027 err_cnt_o SHALL increment per rejected grant, saturating at 255.
REQ-028 With no grant, mem_en_o=mem_we_o=0; mem_addr_o/mem_wdata_o don't-care but SHALL be 0.
REQ-029 Response routing SHALL use a registered owner tag, so a port change between grant and response never misroutes data.

Reset
REQ-030 rst_i SHALL immediately force: state SHARED, last-winner = loader (fetch wins first tie), all gnt/rvalid/mem_en/mem_we/err_o/locked_o = 0, all data outputs 0, err_cnt_o = 0.
REQ-031 Reset asserted with a response pending SHALL discard it; no rvalid after reset release.

Verification
REQ-032 Reset, then if_req_i=1 alone, if_addr_i=0x0000_0004 -> if_gnt_o=1 same cycle, mem_addr_o=0x004; next cycle if_rvalid_o=1, if_rdata_o=mem word.
REQ-033 Both ports request continuously for 4 cycles -> grants alternate fetch, loader, fetch, loader; responses alternate correspondingly one cycle later.
REQ-034 ld_lock_i=1 with if_req_i held -> if_gnt_o=0 from cycle after lock, locked_o=1; ld write 0x0000_0013 to 0x10 then read 0x10 -> ld_rdata_o=0x0000_0013; drop lock -> fetch granted next cycle.
REQ-035 Fetch at 0x0000_0002 and at 0x0000_1000 -> mem_en_o=0, if_rdata_o=32'hDEADBEEF, err_o pulses, err_cnt_o=2; 300 errors -> err_cnt_o=255.
REQ-036 Assert rst_i asynchronously the cycle after a grant -> outputs 0 without waiting for clk_i, no rvalid after release.

Source files
------------

// File: rtl/fetch_arbiter.sv
// Two-port arbiter sharing one synchronous instruction memory between the fetch
// unit and a program loader, with round-robin sharing and an exclusive download lock.
module fetch_arbiter #(
  parameter int unsigned ADDR_BITS = 12,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // fetch port
  input  logic                 if_req_i,
  input  logic [31:0]          if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [31:0]          if_rdata_o,
  // loader port
  input  logic                 ld_req_i,
  input  logic                 ld_we_i,
  input  logic [31:0]          ld_addr_i,
  input  logic [31:0]          ld_wdata_i,
  input  logic                 ld_lock_i,
  output logic                 ld_gnt_o,
  output logic                 ld_rvalid_o,
  output logic [31:0]          ld_rdata_o,
  // memory side
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  // status
  output logic                 locked_o,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic { ST_SHARED, ST_LOCKED } state_e;
  typedef enum logic { OWN_IF, OWN_LD } owner_e;
  typedef enum logic [1:0] { RSP_READ, RSP_WRITE, RSP_ERR } rsp_kind_e;

  state_e     state_q, state_d;
  owner_e     last_q, last_d;
  logic       rsp_valid_q, rsp_valid_d;
  owner_e     rsp_owner_q, rsp_owner_d;
  rsp_kind_e  rsp_kind_q, rsp_kind_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic        if_gnt, ld_gnt, any_gnt;
  logic        win_we, win_bad;
  logic [31:0] win_addr;
  logic [31:0] rsp_data;

  // Misaligned words and addresses beyond the memory are rejected.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> ADDR_BITS) != 32'd0);
  endfunction

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_LOCKED) begin
        ld_gnt = ld_req_i;
      end else if (if_req_i && ld_req_i) begin
        if (last_q == OWN_LD) if_gnt = 1'b1;
        else                  ld_gnt = 1'b1;
      end else begin
        if_gnt = if_req_i;
        ld_gnt = ld_req_i;
      end
    end
  end

  assign any_gnt  = if_gnt | ld_gnt;
  assign win_addr = ld_gnt ? ld_addr_i : if_addr_i;
  assign win_we   = ld_gnt & ld_we_i;
  assign win_bad  = any_gnt & addr_bad(win_addr);

  assign if_gnt_o    = if_gnt;
  assign ld_gnt_o    = ld_gnt;
  assign mem_en_o    = any_gnt & ~win_bad;
  assign mem_we_o    = mem_en_o & win_we;
  assign mem_addr_o  = mem_en_o ? win_addr[ADDR_BITS-1:0] : '0;
  assign mem_wdata_o = mem_we_o ? ld_wdata_i : '0;

  always_comb begin
    state_d     = ld_lock_i ? ST_LOCKED : ST_SHARED;
    last_d      = last_q;
    rsp_valid_d = any_gnt;
    rsp_owner_d = ld_gnt ? OWN_LD : OWN_IF;
    rsp_kind_d  = RSP_READ;
    err_cnt_d   = err_cnt_q;
    if (any_gnt) last_d = ld_gnt ? OWN_LD : OWN_IF;
    if (win_bad)     rsp_kind_d = RSP_ERR;
    else if (win_we) rsp_kind_d = RSP_WRITE;
    if (win_bad && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_SHARED;
      last_q      <= OWN_LD;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWN_IF;
      rsp_kind_q  <= RSP_READ;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_kind_q  <= rsp_kind_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Read data comes straight from the memory in the response cycle; the owner tag steers it.
  always_comb begin
    rsp_data = mem_rdata_i;
    if (rsp_kind_q == RSP_WRITE)    rsp_data = 32'd0;
    else if (rsp_kind_q == RSP_ERR) rsp_data = ERR_DATA;
  end

  assign if_rvalid_o = rsp_valid_q && (rsp_owner_q == OWN_IF);
  assign ld_rvalid_o = rsp_valid_q && (rsp_owner_q == OWN_LD);
  assign if_rdata_o  = if_rvalid_o ? rsp_data : 32'd0;
  assign ld_rdata_o  = ld_rvalid_o ? rsp_data : 32'd0;
  assign err_o       = rsp_valid_q && (rsp_kind_q == RSP_ERR);
  assign locked_o    = (state_q == ST_LOCKED);
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed and randomized bench for fetch_arbiter, checked against a behavioural
// model of the arbitration rules and a shadow copy of the memory contents.
module tb_fetch_arbiter;
  localparam int          AB  = 12;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int          WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          if_req_i, ld_req_i, ld_we_i, ld_lock_i;
  logic [31:0]   if_addr_i, ld_addr_i, ld_wdata_i;
  logic          if_gnt_o, if_rvalid_o, ld_gnt_o, ld_rvalid_o;
  logic [31:0]   if_rdata_o, ld_rdata_o;
  logic          mem_en_o, mem_we_o, locked_o, err_o;
  logic [AB-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic [7:0]    err_cnt_o;

  always #5 clk = ~clk;

  fetch_arbiter #(.ADDR_BITS(AB), .ERR_DATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_lock_i(ld_lock_i), .ld_gnt_o(ld_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  // Synchronous memory attached to the arbiter.
  logic [31:0] tb_mem [WORDS];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) tb_mem[mem_addr_o[AB-1:2]] <= mem_wdata_o;
      else          mem_rdata_i <= tb_mem[mem_addr_o[AB-1:2]];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [WORDS];
  bit          m_locked, m_last_ld, m_rsp_valid, m_rsp_ld, m_rsp_err;
  logic [31:0] m_rsp_data;
  int          m_err_cnt;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0;
    ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_wdata_i = '0; ld_lock_i = 1'b0;
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_last_ld = 1'b1; m_rsp_valid = 1'b0;
    m_rsp_ld = 1'b0; m_rsp_err = 1'b0; m_rsp_data = '0; m_err_cnt = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " if_gnt"}, if_gnt_o, 0);
    check({tag, " ld_gnt"}, ld_gnt_o, 0);
    check({tag, " if_rvalid"}, if_rvalid_o, 0);
    check({tag, " ld_rvalid"}, ld_rvalid_o, 0);
    check({tag, " if_rdata"}, if_rdata_o, 0);
    check({tag, " ld_rdata"}, ld_rdata_o, 0);
    check({tag, " mem_en"}, mem_en_o, 0);
    check({tag, " mem_we"}, mem_we_o, 0);
    check({tag, " mem_addr"}, mem_addr_o, 0);
    check({tag, " mem_wdata"}, mem_wdata_o, 0);
    check({tag, " locked"}, locked_o, 0);
    check({tag, " err"}, err_o, 0);
    check({tag, " err_cnt"}, err_cnt_o, 0);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    idle_inputs();
    #3;
    check_quiet("reset");
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: inputs are already applied; outputs are compared at the
  // falling edge, then the model advances past the rising edge.
  task automatic do_cycle();
    bit          g_if, g_ld, any, bad, wr;
    logic [31:0] a;
    int          idx;
    @(negedge clk);
    check("locked_o", locked_o, m_locked);
    check("err_cnt_o", err_cnt_o, m_err_cnt);
    check("if_rvalid_o", if_rvalid_o, m_rsp_valid && !m_rsp_ld);
    check("ld_rvalid_o", ld_rvalid_o, m_rsp_valid && m_rsp_ld);
    check("if_rdata_o", if_rdata_o, (m_rsp_valid && !m_rsp_ld) ? m_rsp_data : 32'd0);
    check("ld_rdata_o", ld_rdata_o, (m_rsp_valid && m_rsp_ld) ? m_rsp_data : 32'd0);
    check("err_o", err_o, m_rsp_valid && m_rsp_err);

    if (m_locked) begin
      g_if = 1'b0; g_ld = ld_req_i;
    end else if (if_req_i && ld_req_i) begin
      g_if = m_last_ld; g_ld = !m_last_ld;
    end else begin
      g_if = if_req_i; g_ld = ld_req_i;
    end
    check("if_gnt_o", if_gnt_o, g_if);
    check("ld_gnt_o", ld_gnt_o, g_ld);

    any = g_if || g_ld;
    a   = g_ld ? ld_addr_i : if_addr_i;
    wr  = g_ld && ld_we_i;
    bad = (a % 4 != 0) || (a > 32'(WORDS * 4 - 1));
    if (any) begin
      check("mem_en_o", mem_en_o, !bad);
      check("mem_we_o", mem_we_o, !bad && wr);
      if (!bad) check("mem_addr_o", mem_addr_o, a);
      if (!bad && wr) check("mem_wdata_o", mem_wdata_o, ld_wdata_i);
    end else begin
      check("mem_en_o idle", mem_en_o, 0);
      check("mem_we_o idle", mem_we_o, 0);
      check("mem_addr_o idle", mem_addr_o, 0);
    end

    m_rsp_valid = any;
    m_rsp_ld    = g_ld;
    m_rsp_err   = any && bad;
    idx         = int'(a / 4) % WORDS;
    if (!any)     m_rsp_data = '0;
    else if (bad) m_rsp_data = ERR;
    else if (wr)  m_rsp_data = '0;
    else          m_rsp_data = ref_mem[idx];
    if (any && !bad && wr) ref_mem[idx] = ld_wdata_i;
    if (m_rsp_err && m_err_cnt < 255) m_err_cnt++;
    if (any) m_last_ld = g_ld;
    m_locked = ld_lock_i;
    @(posedge clk);
    // NOTE: inputs change 1 time unit after the edge so the DUT never races the bench.
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_bad);
    logic [31:0] a;
    a = {20'd0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
    if (allow_bad && $urandom_range(0, 5) == 0) begin
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else                           a = a | (32'd1 << $urandom_range(AB, 31));
    end
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rdata_i = '0;
    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i]  = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    apply_reset();

    // Single fetch request at word 1.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0004;
    do_cycle();
    idle_inputs();
    check("single fetch rdata", if_rdata_o, 32'hC0DE_0001);
    do_cycle();

    // Both ports busy: fetch wins the first tie after reset, then alternate.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if_req_i = 1'b1; if_addr_i = 32'(4 * (i + 8));
      ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'(4 * (i + 40));
      do_cycle();
    end
    idle_inputs();
    do_cycle();

    // Exclusive lock with fetch held pending.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0020; ld_lock_i = 1'b1;
    do_cycle();
    check("lock locked_o", locked_o, 1);
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h10; ld_wdata_i = 32'h0000_0013;
    do_cycle();
    ld_we_i = 1'b0; ld_wdata_i = '0;
    do_cycle();
    check("lock readback", ld_rdata_o, 32'h0000_0013);
    ld_req_i = 1'b0; ld_lock_i = 1'b0;
    do_cycle();
    do_cycle();
    idle_inputs();
    do_cycle();

    // Rejected accesses and counter saturation.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0002;
    do_cycle();
    if_addr_i = 32'h0000_1000;
    do_cycle();
    idle_inputs();
    do_cycle();
    check("err_cnt after two", err_cnt_o, 8'd2);
    for (int i = 0; i < 300; i++) begin
      if_req_i  = 1'($urandom_range(0, 1));
      ld_req_i  = !if_req_i || 1'($urandom_range(0, 1));
      ld_we_i   = 1'($urandom_range(0, 1));
      if_addr_i = {20'($urandom_range(1, 1023)), 12'($urandom_range(0, 4095))};
      ld_addr_i = {$urandom_range(0, 1023) | 32'h1000} | 32'($urandom_range(0, 3));
      ld_wdata_i = $urandom;
      do_cycle();
    end
    idle_inputs();
    do_cycle();
    check("err_cnt saturated", err_cnt_o, 8'd255);

    // Random traffic, occasional lock windows.
    for (int i = 0; i < 250; i++) begin
      if_req_i   = 1'($urandom_range(0, 1));
      if_addr_i  = rand_addr(1'b1);
      ld_req_i   = 1'($urandom_range(0, 1));
      ld_we_i    = 1'($urandom_range(0, 1));
      ld_addr_i  = rand_addr(1'b1);
      ld_wdata_i = $urandom;
      if ($urandom_range(0, 7) == 0) ld_lock_i = !ld_lock_i;
      do_cycle();
    end
    idle_inputs();
    do_cycle();
    do_cycle();

    // Asynchronous reset while a fetch response is pending.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0008;
    do_cycle();
    #1;
    rst_i = 1'b1;
    #1;
    check_quiet("async reset");
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    do_cycle();
    do_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
